// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter that serialises SRAM transactions onto a single
// controller interface, routes read data back and aborts hung reads on timeout.
module sram_arbiter #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iReq0,
  input  logic              iWrite0,
  input  logic [ADDR_W-1:0] iAddr0,
  input  logic [DATA_W-1:0] iWData0,
  output logic              oGnt0,
  output logic              oRValid0,
  output logic [DATA_W-1:0] oRData0,
  output logic              oRErr0,
  input  logic              iReq1,
  input  logic              iWrite1,
  input  logic [ADDR_W-1:0] iAddr1,
  input  logic [DATA_W-1:0] iWData1,
  output logic              oGnt1,
  output logic              oRValid1,
  output logic [DATA_W-1:0] oRData1,
  output logic              oRErr1,
  output logic [ADDR_W-1:0] oAddress,
  output logic [DATA_W-1:0] oWData,
  output logic              oValidRequest,
  output logic              oWrite,
  input  logic              iAck,
  input  logic              iValidRead,
  input  logic [DATA_W-1:0] iRData,
  output logic              oBusy
);

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t           r_state;
  logic             r_last;   // last granted port; also owner of the live transaction
  logic [CNT_W-1:0] r_cnt;

  logic w_pick1;
  logic w_tmo;
  logic w_ret;
  logic w_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == TMO) ? c : c + CNT_W'(1);
  endfunction

  // With both ports requesting, the port that was not served last wins.
  assign w_pick1 = iReq1 && (!iReq0 || !r_last);
  assign w_tmo   = (sat_inc(r_cnt) == TMO);

  always_comb begin
    w_ret = 1'b0;
    w_err = 1'b0;
    case (r_state)
      ISSUE: begin
        if (iAck) begin
          w_ret = !oWrite && iValidRead;
        end else if (w_tmo) begin
          w_ret = !oWrite;
          w_err = !oWrite;
        end
      end
      WAIT_RD: begin
        if (iValidRead) begin
          w_ret = 1'b1;
        end else if (w_tmo) begin
          w_ret = 1'b1;
          w_err = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state       <= IDLE;
      r_last        <= 1'b1;
      r_cnt         <= '0;
      oGnt0         <= 1'b0;
      oGnt1         <= 1'b0;
      oRValid0      <= 1'b0;
      oRValid1      <= 1'b0;
      oRErr0        <= 1'b0;
      oRErr1        <= 1'b0;
      oRData0       <= '0;
      oRData1       <= '0;
      oAddress      <= '0;
      oWData        <= '0;
      oValidRequest <= 1'b0;
      oWrite        <= 1'b0;
      oBusy         <= 1'b0;
    end else begin
      oGnt0    <= 1'b0;
      oGnt1    <= 1'b0;
      oRValid0 <= 1'b0;
      oRValid1 <= 1'b0;
      oRErr0   <= 1'b0;
      oRErr1   <= 1'b0;

      if (w_ret) begin
        if (r_last) begin
          oRValid1 <= 1'b1;
          oRErr1   <= w_err;
          oRData1  <= w_err ? '0 : iRData;
        end else begin
          oRValid0 <= 1'b1;
          oRErr0   <= w_err;
          oRData0  <= w_err ? '0 : iRData;
        end
      end

      case (r_state)
        IDLE: begin
          if (iReq0 || iReq1) begin
            r_last        <= w_pick1;
            oGnt0         <= !w_pick1;
            oGnt1         <= w_pick1;
            oAddress      <= w_pick1 ? iAddr1  : iAddr0;
            oWData        <= w_pick1 ? iWData1 : iWData0;
            oWrite        <= w_pick1 ? iWrite1 : iWrite0;
            oValidRequest <= 1'b1;
            oBusy         <= 1'b1;
            r_cnt         <= '0;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt <= sat_inc(r_cnt);
          if (iAck) begin
            oValidRequest <= 1'b0;
            r_cnt         <= '0;
            if (!oWrite && !iValidRead) begin
              r_state <= WAIT_RD;
            end else begin
              r_state <= IDLE;
              oBusy   <= 1'b0;
            end
          end else if (w_tmo) begin
            oValidRequest <= 1'b0;
            r_state       <= IDLE;
            oBusy         <= 1'b0;
          end
        end
        WAIT_RD: begin
          r_cnt <= sat_inc(r_cnt);
          if (iValidRead || w_tmo) begin
            r_state <= IDLE;
            oBusy   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          oBusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed stimulus pushes expected grants
// and read returns; a negedge monitor pops and compares them as they appear.
module tb_sram_arbiter;

  localparam int AW  = 22;
  localparam int DW  = 16;
  localparam int TMO = 16;

  logic          iClock = 1'b0;
  logic          iReset;
  logic          iReq0, iWrite0, iReq1, iWrite1;
  logic [AW-1:0] iAddr0, iAddr1;
  logic [DW-1:0] iWData0, iWData1;
  logic          oGnt0, oRValid0, oRErr0, oGnt1, oRValid1, oRErr1;
  logic [DW-1:0] oRData0, oRData1;
  logic [AW-1:0] oAddress;
  logic [DW-1:0] oWData;
  logic          oValidRequest, oWrite, iAck, iValidRead, oBusy;
  logic [DW-1:0] iRData;

  typedef struct packed {
    logic          port;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
  } gnt_t;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
    logic          err;
  } ret_t;

  gnt_t exp_g[$];
  ret_t exp_r[$];
  int   checks   = 0;
  int   failures = 0;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .iClock(iClock), .iReset(iReset),
    .iReq0(iReq0), .iWrite0(iWrite0), .iAddr0(iAddr0), .iWData0(iWData0),
    .oGnt0(oGnt0), .oRValid0(oRValid0), .oRData0(oRData0), .oRErr0(oRErr0),
    .iReq1(iReq1), .iWrite1(iWrite1), .iAddr1(iAddr1), .iWData1(iWData1),
    .oGnt1(oGnt1), .oRValid1(oRValid1), .oRData1(oRData1), .oRErr1(oRErr1),
    .oAddress(oAddress), .oWData(oWData), .oValidRequest(oValidRequest),
    .oWrite(oWrite), .iAck(iAck), .iValidRead(iValidRead), .iRData(iRData),
    .oBusy(oBusy)
  );

  always #5 iClock = ~iClock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every grant and every read return must match the head of its queue.
  always @(negedge iClock) begin
    if (!iReset) begin
      if (oGnt0 && oGnt1) chk("two_grants", 2, 1);
      if (oGnt0 || oGnt1) begin
        if (exp_g.size() == 0) begin
          chk("unexpected_grant", {30'd0, oGnt1, oGnt0}, 0);
        end else begin
          gnt_t g;
          g = exp_g.pop_front();
          chk("gnt_port", {31'd0, oGnt1}, {31'd0, g.port});
          chk("gnt_addr", {10'd0, oAddress}, {10'd0, g.addr});
          chk("gnt_wdata", {16'd0, oWData}, {16'd0, g.wdata});
          chk("gnt_write", {31'd0, oWrite}, {31'd0, g.wr});
          chk("gnt_vreq", {31'd0, oValidRequest}, 1);
        end
      end
      if (oRValid0 || oRValid1) begin
        if (exp_r.size() == 0) begin
          chk("unexpected_rvalid", {30'd0, oRValid1, oRValid0}, 0);
        end else begin
          ret_t r;
          r = exp_r.pop_front();
          chk("ret_port", {30'd0, oRValid1, oRValid0}, r.port ? 2 : 1);
          chk("ret_data", {16'd0, r.port ? oRData1 : oRData0}, {16'd0, r.data});
          chk("ret_err", {31'd0, r.port ? oRErr1 : oRErr0}, {31'd0, r.err});
        end
      end
    end
  end

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic request(input logic p, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    gnt_t g;
    if (p) begin
      iReq1 = 1'b1; iWrite1 = wr; iAddr1 = a; iWData1 = d;
    end else begin
      iReq0 = 1'b1; iWrite0 = wr; iAddr0 = a; iWData0 = d;
    end
    g.port = p; g.addr = a; g.wdata = d; g.wr = wr;
    exp_g.push_back(g);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!oValidRequest && n < 50) begin
      step();
      n++;
    end
    chk(name, {31'd0, oValidRequest}, 1);
  endtask

  task automatic pulse_ack();
    iAck = 1'b1;
    step();
    iAck = 1'b0;
  endtask

  task automatic pulse_vr(input logic [DW-1:0] d);
    iValidRead = 1'b1;
    iRData     = d;
    step();
    iValidRead = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, {10'd0, oAddress}, 0);
    chk({tag, "_wdata"}, {16'd0, oWData}, 0);
    chk({tag, "_ctl"}, {24'd0, oValidRequest, oWrite, oBusy, oGnt0, oGnt1,
                        oRValid0, oRValid1, oRErr0 | oRErr1}, 0);
    chk({tag, "_rdata"}, {oRData1, oRData0}, 0);
  endtask

  initial begin
    ret_t r;
    int   n;
    iReset = 1'b1; iReq0 = 0; iReq1 = 0; iWrite0 = 0; iWrite1 = 0;
    iAddr0 = '0; iAddr1 = '0; iWData0 = '0; iWData1 = '0;
    iAck = 0; iValidRead = 0; iRData = '0;
    repeat (3) step();
    iReset = 1'b0;
    chk_all_zero("reset");

    // Port 0 write, ack two cycles after the grant
    request(1'b0, 1'b1, 22'h000010, 16'hBEEF);
    wait_req("t1_grant");
    iReq0 = 1'b0;
    step();
    chk("t1_gnt_pulse", {31'd0, oGnt0}, 0);
    chk("t1_hold", {oValidRequest, oWrite, oBusy, 7'd0, oAddress}, {3'b111, 7'd0, 22'h10});
    chk("t1_hold_wdata", {16'd0, oWData}, 32'hBEEF);
    pulse_ack();
    chk("t1_idle", {30'd0, oValidRequest, oBusy}, 0);

    // Port 1 read, data four cycles after the ack
    request(1'b1, 1'b0, 22'h3FFFFF, 16'h0000);
    wait_req("t2_grant");
    iReq1 = 1'b0;
    pulse_ack();
    chk("t2_vreq_drop", {31'd0, oValidRequest}, 0);
    r.port = 1'b1; r.data = 16'h1234; r.err = 1'b0;
    exp_r.push_back(r);
    repeat (3) step();
    pulse_vr(16'h1234);
    chk("t2_rvalid1", {30'd0, oRValid1, oRValid0}, 2);

    // Both ports held for six back-to-back writes
    for (int i = 0; i < 6; i++) begin
      gnt_t g;
      g.port = i[0]; g.wr = 1'b1;
      g.addr = i[0] ? 22'h000200 : 22'h000100;
      g.wdata = i[0] ? 16'h2222 : 16'h1111;
      exp_g.push_back(g);
    end
    iReq0 = 1; iWrite0 = 1; iAddr0 = 22'h100; iWData0 = 16'h1111;
    iReq1 = 1; iWrite1 = 1; iAddr1 = 22'h200; iWData1 = 16'h2222;
    for (int i = 0; i < 6; i++) begin
      wait_req("t3_grant");
      if (i == 5) begin
        iReq0 = 0;
        iReq1 = 0;
      end
      pulse_ack();
    end

    // Ack and read data in the same cycle
    request(1'b0, 1'b0, 22'h000055, 16'h0000);
    wait_req("t6_grant");
    iReq0 = 1'b0;
    r.port = 1'b0; r.data = 16'hA5A5; r.err = 1'b0;
    exp_r.push_back(r);
    iAck = 1'b1;
    pulse_vr(16'hA5A5);
    iAck = 1'b0;
    chk("t6_rvalid0", {31'd0, oRValid0}, 1);
    chk("t6_idle", {31'd0, oBusy}, 0);
    chk("t6_rdata1_hold", {16'd0, oRData1}, 32'h1234);

    // Port 0 read that never returns data while port 1 waits
    request(1'b0, 1'b0, 22'h000077, 16'h0000);
    wait_req("t4_grant0");
    iReq0 = 1'b0;
    request(1'b1, 1'b1, 22'h000099, 16'h9999);
    r.port = 1'b0; r.data = 16'h0000; r.err = 1'b1;
    exp_r.push_back(r);
    pulse_ack();
    n = 0;
    while (!oRValid0 && n < 100) begin
      step();
      n++;
    end
    chk("t4_latency", n, TMO);
    chk("t4_err", {oRValid0, oRErr0, 14'd0, oRData0}, {2'b11, 30'd0});
    wait_req("t4_grant1");
    iReq1 = 1'b0;
    pulse_ack();

    // Reset while waiting for read data
    request(1'b0, 1'b0, 22'h000042, 16'h0000);
    wait_req("t5_grant");
    iReq0 = 1'b0;
    pulse_ack();
    step();
    chk("t5_busy_before", {31'd0, oBusy}, 1);
    iReset = 1'b1;
    step();
    iReset = 1'b0;
    chk_all_zero("t5_reset");
    pulse_vr(16'hDEAD);
    iAck = 1'b1;
    step();
    iAck = 1'b0;
    chk("t5_stray_ignored", {30'd0, oBusy, oValidRequest}, 0);
    request(1'b1, 1'b1, 22'h000300, 16'h3333);
    request(1'b0, 1'b1, 22'h000400, 16'h4444);
    exp_g.delete();
    begin
      gnt_t g;
      g.port = 1'b0; g.wr = 1'b1; g.addr = 22'h400; g.wdata = 16'h4444;
      exp_g.push_back(g);
      g.port = 1'b1; g.addr = 22'h300; g.wdata = 16'h3333;
      exp_g.push_back(g);
    end
    for (int i = 0; i < 2; i++) begin
      wait_req("t5_grant_after");
      if (i == 1) begin
        iReq0 = 0;
        iReq1 = 0;
      end
      pulse_ack();
    end

    repeat (4) step();
    chk("grants_left", exp_g.size(), 0);
    chk("returns_left", exp_r.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port round-robin arbiter and transaction sequencer in front of the single SRAM controller.
- Port 0 is the memory controller's UART loader path. Port 1 is the graphics-pipeline fetch path (vertex/object reads).
- Serialises one transaction at a time onto the controller's address/data/request/write interface and routes read data back to the granted requester.
- Provides a read timeout so a hung controller cannot deadlock either requester.

Parameters:
- ADDR_W, 22, SRAM word address width.
- DATA_W, 16, SRAM data width.
- TIMEOUT, 1023, max cycles to wait for a read return or accept before aborting; 10-bit counter; must be ≥1.

Ports:
- iClock  in  1  system clock
- iReset  in  1  synchronous active-high reset
- iReq0  in  1  port 0 request, held until oGnt0
- iWrite0  in  1  port 0: 1 = write, 0 = read
- iAddr0  in  ADDR_W  port 0 address
- iWData0  in  DATA_W  port 0 write data
- oGnt0  out  1  port 0 grant/accept pulse
- oRValid0  out  1  port 0 read-return pulse
- oRData0  out  DATA_W  port 0 read data
- oRErr0  out  1  port 0 timeout flag, valid with oRValid0
- iReq1, iWrite1, iAddr1, iWData1, oGnt1, oRValid1, oRData1, oRErr1: same as port 0, for port 1
- oAddress  out  ADDR_W  to SRAM controller
- oWData  out  DATA_W  to SRAM controller
- oValidRequest  out  1  request to SRAM controller
- oWrite  out  1  write qualifier to SRAM controller
- iAck  in  1  controller accepted the request (1-cycle pulse)
- iValidRead  in  1  controller read data valid (1-cycle pulse)
- iRData  in  DATA_W  controller read data
- oBusy  out  1  arbiter not in IDLE

Behaviour:
- All outputs are registered.
- Reset (synchronous, iReset=1 at posedge):
  - State goes to IDLE; round-robin pointer last=1, so port 0 wins first.
  - All outputs are 0, including oAddress, oWData and oRData0/1.
  - Timeout counter cleared.
  - Reset mid-transaction aborts it silently: no oRValid pulse, oValidRequest drops next cycle.
- States: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - Only one requesting: select it.
  - Both requesting: select the port ≠ last.
  - Latch addr/wdata/write into oAddress/oWData/oWrite.
  - Set oValidRequest=1, pulse oGntN for exactly 1 cycle, set last=N, clear counter, go to ISSUE.
  - Requester sees oGntN and must drop or renew iReqN the following cycle.
  - Requests are sampled only in IDLE.
- ISSUE:
  - Hold oValidRequest, oAddress, oWData and oWrite stable until iAck.
  - iAck on a write: drop oValidRequest, go to IDLE. No completion pulse; oGnt is the only write handshake.
  - iAck on a read: drop oValidRequest, go to WAIT_RD, clear counter.
  - Counter reaches TIMEOUT without iAck: drop oValidRequest, go to IDLE. A read also pulses oRValidN=1 with oRErrN=1 and oRDataN=0.
- WAIT_RD:
  - iValidRead: oRDataN←iRData, oRValidN=1, oRErrN=0 for 1 cycle, go to IDLE.
  - Counter reaches TIMEOUT: error return as in ISSUE, go to IDLE.
  - The non-granted port's oRData holds its previous value.
- Simultaneous iAck and iValidRead in ISSUE for a read: treat as ack plus data. Return data immediately and go to IDLE.
- iAck or iValidRead outside the expected state is ignored.
- Minimum turnaround: IDLE→ISSUE→IDLE, 3 cycles per write with a 1-cycle ack. Back-to-back same-port requests alternate fairly with the other port.
- oBusy = (state ≠ IDLE).
- Counter increments every cycle in ISSUE/WAIT_RD and saturates at TIMEOUT.

Test Plan:
- Reset, then iReq0 write addr=22'h000010 data=16'hBEEF, iAck 2 cycles later.
  -> oGnt0 pulse 1 cycle; oAddress=0x10, oWData=0xBEEF, oWrite=1 held until iAck; back to IDLE; no oRValid0.
- Port 1 read addr=0x3FFFFF; iAck, then iValidRead 4 cycles later with iRData=0x1234.
  -> oRValid1=1 for 1 cycle, oRData1=0x1234, oRErr1=0; oRValid0 stays 0.
- iReq0 and iReq1 both held high for 6 transactions.
  -> grant order 0,1,0,1,0,1; never two grants in one cycle.
- Read on port 0, controller never returns iValidRead.
  -> after TIMEOUT cycles oRValid0=1, oRErr0=1, oRData0=0; arbiter returns to IDLE and serves a pending iReq1.
- iReset asserted while in WAIT_RD.
  -> next cycle all outputs 0, oBusy=0, no oRValid pulse; a subsequent simultaneous request grants port 0 first.
- iAck and iValidRead in the same cycle for a read (iRData=0xA5A5).
  -> oRValid of the granted port with data 0xA5A5 next cycle; state returns to IDLE.
